// File: rtl/elevator_car_sched.sv
// elevator_car_sched
//   Single-car elevator controller. Latches hall and car calls into lamps,
//   picks travel direction with collective-selective scheduling, and runs
//   door and travel phases from deterministic cycle timers.
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-high reset
//   hall_up_req    per-floor up-call requests (top-floor bit ignored)
//   hall_dn_req    per-floor down-call requests (floor-0 bit ignored)
//   car_req        in-car floor buttons
//   door_obstruct  obstruction sensor, only acted on while the door is closing
//   floor          current car floor
//   dir_up         1 = travelling/serving upward, 0 = downward
//   moving         high while the car travels between floors
//   door           0 CLOSED, 1 OPENING, 2 OPEN, 3 CLOSING
//   arrive         one-cycle pulse in the first cycle at a new floor
//   hall_up_lit, hall_dn_lit, car_lit   latched call lamps
module elevator_car_sched #(
  parameter int NUM_FLOORS = 6,
  parameter int FLOOR_W    = 3,
  parameter int INIT_FLOOR = 0,
  parameter int TRAVEL_CYC = 4,
  parameter int DOOR_CYC   = 2,
  parameter int HOLD_CYC   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] hall_up_req,
  input  logic [NUM_FLOORS-1:0] hall_dn_req,
  input  logic [NUM_FLOORS-1:0] car_req,
  input  logic                  door_obstruct,
  output logic [FLOOR_W-1:0]    floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic [1:0]            door,
  output logic                  arrive,
  output logic [NUM_FLOORS-1:0] hall_up_lit,
  output logic [NUM_FLOORS-1:0] hall_dn_lit,
  output logic [NUM_FLOORS-1:0] car_lit
);

  localparam int TMR_W = 16;
  localparam logic [FLOOR_W-1:0]    TOP     = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [NUM_FLOORS-1:0] ONE     = NUM_FLOORS'(1);
  localparam logic [NUM_FLOORS-1:0] UP_OK   = ~(ONE << (NUM_FLOORS - 1));
  localparam logic [NUM_FLOORS-1:0] DN_OK   = ~ONE;
  localparam logic [TMR_W-1:0]      T_DOOR  = TMR_W'(DOOR_CYC - 1);
  localparam logic [TMR_W-1:0]      T_HOLD  = TMR_W'(HOLD_CYC - 1);
  localparam logic [TMR_W-1:0]      T_TRAV  = TMR_W'(TRAVEL_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_OPENING, S_OPEN, S_CLOSING, S_MOVING} state_t;

  state_t                  state_q, state_d;
  logic [FLOOR_W-1:0]      floor_q, floor_d;
  logic                    dir_q, dir_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic                    arrive_q, arrive_d;
  logic [NUM_FLOORS-1:0]   car_q, car_d, up_q, up_d, dn_q, dn_d;

  logic [NUM_FLOORS-1:0]   all_lit, clr_oh;
  logic [FLOOR_W-1:0]      floor_nx;
  logic                    dir_nx, here_nx, ahead_nx, hold_hit;
  logic                    srv_up_cur, srv_dn_cur, srv_up_nx, srv_dn_nx;

  // Any lamp strictly above (up=1) or strictly below (up=0) floor g.
  function automatic logic lamps_beyond(input logic [NUM_FLOORS-1:0] v,
                                        input logic [FLOOR_W-1:0] g, input logic up);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (v[i] && (up ? (i > int'(g)) : (i < int'(g)))) hit = 1'b1;
    end
    return hit;
  endfunction

  // Call at floor g that a stop in direction d serves.
  function automatic logic here_dir(input logic [NUM_FLOORS-1:0] c, input logic [NUM_FLOORS-1:0] u,
                                    input logic [NUM_FLOORS-1:0] dn, input logic [FLOOR_W-1:0] g,
                                    input logic d);
    return c[g] | (d ? u[g] : dn[g]);
  endfunction

  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    dir_d    = dir_q;
    timer_d  = timer_q;
    arrive_d = 1'b0;
    all_lit  = car_q | up_q | dn_q;

    // Floor and direction the car would have after completing the current hop.
    floor_nx = dir_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
    dir_nx   = dir_q;
    if (floor_nx == TOP) dir_nx = 1'b0;
    else if (floor_nx == '0) dir_nx = 1'b1;
    here_nx  = here_dir(car_q, up_q, dn_q, floor_nx, dir_nx);
    ahead_nx = lamps_beyond(all_lit, floor_nx, dir_nx);

    // A press at the floor being served while OPEN keeps the door open longer.
    srv_up_cur = dir_q | (floor_q == '0) | (floor_q == TOP);
    srv_dn_cur = ~dir_q | (floor_q == '0) | (floor_q == TOP);
    hold_hit   = car_req[floor_q] | (srv_up_cur & UP_OK[floor_q] & hall_up_req[floor_q])
               | (srv_dn_cur & DN_OK[floor_q] & hall_dn_req[floor_q]);

    case (state_q)
      S_IDLE: begin
        if (here_dir(car_q, up_q, dn_q, floor_q, dir_q)) begin
          state_d = S_OPENING;
          timer_d = T_DOOR;
        end else if ((dir_q ? dn_q[floor_q] : up_q[floor_q])
                     && !lamps_beyond(all_lit, floor_q, dir_q)) begin
          // Opposite-direction hall call here and nothing ahead: turn around and serve it.
          dir_d   = ~dir_q;
          state_d = S_OPENING;
          timer_d = T_DOOR;
        end else if (lamps_beyond(all_lit, floor_q, dir_q)) begin
          state_d = S_MOVING;
          timer_d = T_TRAV;
        end else if (lamps_beyond(all_lit, floor_q, ~dir_q)) begin
          dir_d   = ~dir_q;
          state_d = S_MOVING;
          timer_d = T_TRAV;
        end
      end
      S_OPENING: begin
        if (timer_q == '0) begin
          state_d = S_OPEN;
          timer_d = T_HOLD;
        end else timer_d = timer_q - TMR_W'(1);
      end
      S_OPEN: begin
        if (hold_hit) timer_d = T_HOLD;
        else if (timer_q == '0) begin
          state_d = S_CLOSING;
          timer_d = T_DOOR;
        end else timer_d = timer_q - TMR_W'(1);
      end
      S_CLOSING: begin
        if (door_obstruct) begin
          state_d = S_OPENING;
          timer_d = T_DOOR;
        end else if (timer_q == '0) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else timer_d = timer_q - TMR_W'(1);
      end
      S_MOVING: begin
        if (timer_q == '0) begin
          floor_d  = floor_nx;
          dir_d    = dir_nx;
          arrive_d = 1'b1;
          if (here_nx || !ahead_nx) begin
            // Stopping with only an opposite hall call here: face its direction.
            if (!here_nx && (dir_nx ? dn_q[floor_nx] : up_q[floor_nx])) dir_d = ~dir_nx;
            state_d = S_OPENING;
            timer_d = T_DOOR;
          end else timer_d = T_TRAV;
        end else timer_d = timer_q - TMR_W'(1);
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase

    // Lamps latch requests; while the door is opening/open at a floor its served lamps stay clear.
    srv_up_nx = dir_d | (floor_d == '0) | (floor_d == TOP);
    srv_dn_nx = ~dir_d | (floor_d == '0) | (floor_d == TOP);
    clr_oh    = '0;
    if (state_d == S_OPENING || state_d == S_OPEN) clr_oh = ONE << floor_d;
    car_d = (car_q | car_req) & ~clr_oh;
    up_d  = (up_q | hall_up_req) & UP_OK & ~(srv_up_nx ? clr_oh : '0);
    dn_d  = (dn_q | hall_dn_req) & DN_OK & ~(srv_dn_nx ? clr_oh : '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      floor_q  <= FLOOR_W'(INIT_FLOOR);
      dir_q    <= 1'b1;
      timer_q  <= '0;
      arrive_q <= 1'b0;
      car_q    <= '0;
      up_q     <= '0;
      dn_q     <= '0;
    end else begin
      state_q  <= state_d;
      floor_q  <= floor_d;
      dir_q    <= dir_d;
      timer_q  <= timer_d;
      arrive_q <= arrive_d;
      car_q    <= car_d;
      up_q     <= up_d;
      dn_q     <= dn_d;
    end
  end

  always_comb begin
    case (state_q)
      S_OPENING: door = 2'd1;
      S_OPEN:    door = 2'd2;
      S_CLOSING: door = 2'd3;
      default:   door = 2'd0;
    endcase
  end

  assign moving      = (state_q == S_MOVING);
  assign floor       = floor_q;
  assign dir_up      = dir_q;
  assign arrive      = arrive_q;
  assign car_lit     = car_q;
  assign hall_up_lit = up_q;
  assign hall_dn_lit = dn_q;

endmodule

// File: tb/tb_elevator_car_sched.sv
// tb_elevator_car_sched
//   Directed stimulus for elevator_car_sched with a behavioural reference model
//   compared every cycle, plus hand-computed literal expectations per scenario.
module tb_elevator_car_sched;

  localparam int NF = 6;
  localparam int TRAVEL = 4;
  localparam int DOORC = 2;
  localparam int HOLDC = 3;
  localparam int PH_IDLE = 0, PH_OPENING = 1, PH_OPEN = 2, PH_CLOSING = 3, PH_MOVING = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NF-1:0] hall_up_req = '0;
  logic [NF-1:0] hall_dn_req = '0;
  logic [NF-1:0] car_req = '0;
  logic          door_obstruct = 1'b0;
  logic [2:0]    floor;
  logic          dir_up, moving, arrive;
  logic [1:0]    door;
  logic [NF-1:0] hall_up_lit, hall_dn_lit, car_lit;

  int n_cmp = 0;
  int n_bad = 0;

  elevator_car_sched #(
    .NUM_FLOORS(NF), .FLOOR_W(3), .INIT_FLOOR(0),
    .TRAVEL_CYC(TRAVEL), .DOOR_CYC(DOORC), .HOLD_CYC(HOLDC)
  ) dut (
    .clk(clk), .reset(reset),
    .hall_up_req(hall_up_req), .hall_dn_req(hall_dn_req), .car_req(car_req),
    .door_obstruct(door_obstruct),
    .floor(floor), .dir_up(dir_up), .moving(moving), .door(door), .arrive(arrive),
    .hall_up_lit(hall_up_lit), .hall_dn_lit(hall_dn_lit), .car_lit(car_lit)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_floor = 0;
  bit m_up = 1'b1;
  int m_ph = PH_IDLE;
  int m_el = 0;
  bit m_arr = 1'b0;
  bit m_car[NF];
  bit m_hu[NF];
  bit m_hd[NF];

  function automatic bit m_lit_at(int f);
    return m_car[f] || m_hu[f] || m_hd[f];
  endfunction

  function automatic bit m_any_lit();
    bit r = 1'b0;
    for (int f = 0; f < NF; f++) if (m_lit_at(f)) r = 1'b1;
    return r;
  endfunction

  function automatic bit m_ahead(int g, bit up);
    bit r = 1'b0;
    for (int f = 0; f < NF; f++) if ((up ? f > g : f < g) && m_lit_at(f)) r = 1'b1;
    return r;
  endfunction

  function automatic bit m_here(int g, bit up);
    return m_car[g] || (up ? m_hu[g] : m_hd[g]);
  endfunction

  function automatic bit m_other(int g, bit up);
    return up ? m_hd[g] : m_hu[g];
  endfunction

  function automatic logic [NF-1:0] mvec(int which);
    logic [NF-1:0] v = '0;
    for (int f = 0; f < NF; f++)
      v[f] = (which == 0) ? m_car[f] : (which == 1) ? m_hu[f] : m_hd[f];
    return v;
  endfunction

  task automatic model_reset();
    m_floor = 0; m_up = 1'b1; m_ph = PH_IDLE; m_el = 0; m_arr = 1'b0;
    for (int f = 0; f < NF; f++) begin m_car[f] = 0; m_hu[f] = 0; m_hd[f] = 0; end
  endtask

  task automatic model_step();
    int nf, nph, nel;
    bit nup, narr, hold, sup, sdn;
    nf = m_floor; nup = m_up; nph = m_ph; nel = m_el + 1; narr = 1'b0;
    sup = m_up || m_floor == 0 || m_floor == NF - 1;
    sdn = !m_up || m_floor == 0 || m_floor == NF - 1;
    hold = car_req[m_floor] || (sup && m_floor < NF - 1 && hall_up_req[m_floor])
        || (sdn && m_floor > 0 && hall_dn_req[m_floor]);
    case (m_ph)
      PH_IDLE: begin
        nel = 0;
        if (m_here(m_floor, m_up)) nph = PH_OPENING;
        else if (m_other(m_floor, m_up) && !m_ahead(m_floor, m_up)) begin nup = !m_up; nph = PH_OPENING; end
        else if (m_ahead(m_floor, m_up)) nph = PH_MOVING;
        else if (m_ahead(m_floor, !m_up)) begin nup = !m_up; nph = PH_MOVING; end
      end
      PH_OPENING: if (nel == DOORC) begin nph = PH_OPEN; nel = 0; end
      PH_OPEN: begin
        if (hold) nel = 0;
        else if (nel == HOLDC) begin nph = PH_CLOSING; nel = 0; end
      end
      PH_CLOSING: begin
        if (door_obstruct) begin nph = PH_OPENING; nel = 0; end
        else if (nel == DOORC) begin nph = PH_IDLE; nel = 0; end
      end
      default: begin
        if (nel == TRAVEL) begin
          nf = m_up ? m_floor + 1 : m_floor - 1;
          narr = 1'b1; nel = 0;
          if (nf == NF - 1) nup = 1'b0;
          else if (nf == 0) nup = 1'b1;
          if (m_here(nf, nup) || !m_ahead(nf, nup)) begin
            if (!m_here(nf, nup) && m_other(nf, nup)) nup = !nup;
            nph = PH_OPENING;
          end
        end
      end
    endcase
    for (int f = 0; f < NF; f++) begin
      m_car[f] = m_car[f] | car_req[f];
      if (f < NF - 1) m_hu[f] = m_hu[f] | hall_up_req[f];
      if (f > 0) m_hd[f] = m_hd[f] | hall_dn_req[f];
    end
    if (nph == PH_OPENING || nph == PH_OPEN) begin
      m_car[nf] = 1'b0;
      if (nup || nf == 0 || nf == NF - 1) m_hu[nf] = 1'b0;
      if (!nup || nf == 0 || nf == NF - 1) m_hd[nf] = 1'b0;
    end
    m_floor = nf; m_up = nup; m_ph = nph; m_el = nel; m_arr = narr;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else model_step();
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("cmp floor", 32'(floor), 32'(m_floor));
      chk("cmp dir_up", 32'(dir_up), 32'(m_up));
      chk("cmp moving", 32'(moving), 32'(m_ph == PH_MOVING));
      chk("cmp door", 32'(door), (m_ph == PH_MOVING) ? 32'd0 : 32'(m_ph));
      chk("cmp arrive", 32'(arrive), 32'(m_arr));
      chk("cmp car_lit", 32'(car_lit), 32'(mvec(0)));
      chk("cmp hall_up_lit", 32'(hall_up_lit), 32'(mvec(1)));
      chk("cmp hall_dn_lit", 32'(hall_dn_lit), 32'(mvec(2)));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int opens[4];
  int n_opens;

  // Run until the model is idle with no lamps, recording floors where the DUT door starts opening.
  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    logic [1:0] pd = door;
    n_opens = 0;
    while (!(m_ph == PH_IDLE && !m_any_lit()) && n < budget) begin
      tick(1); n++;
      if (pd == 2'd0 && door == 2'd1 && n_opens < 4) begin opens[n_opens] = int'(floor); n_opens++; end
      pd = door;
    end
    if (n >= budget) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: timeout after %0d cycles, required idle", nm, n);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst floor", 32'(floor), 0);
    chk("rst dir_up", 32'(dir_up), 1);
    chk("rst door", 32'(door), 0);
    chk("rst moving", 32'(moving), 0);
    chk("rst arrive", 32'(arrive), 0);
    chk("rst lamps", 32'({car_lit, hall_up_lit, hall_dn_lit}), 0);
    reset = 1'b0;
    tick(1);

    // car call to floor 3 from floor 0
    car_req = 6'b001000; tick(1); car_req = '0;
    chk("t1 car_lit latched", 32'(car_lit), 8);
    chk("t1 not yet moving", 32'(moving), 0);
    tick(1);
    chk("t1 moving", 32'(moving), 1);
    chk("t1 still floor0", 32'(floor), 0);
    tick(4);
    chk("t1 floor1", 32'(floor), 1);
    chk("t1 arrive1", 32'(arrive), 1);
    tick(1);
    chk("t1 arrive pulse ends", 32'(arrive), 0);
    tick(3);
    chk("t1 floor2", 32'(floor), 2);
    chk("t1 arrive2", 32'(arrive), 1);
    tick(4);
    chk("t1 floor3", 32'(floor), 3);
    chk("t1 arrive3", 32'(arrive), 1);
    chk("t1 door opening", 32'(door), 1);
    chk("t1 car_lit cleared", 32'(car_lit), 0);
    tick(1); chk("t1 opening 2nd", 32'(door), 1);
    tick(1); chk("t1 open", 32'(door), 2);
    tick(2); chk("t1 open 3rd", 32'(door), 2);
    tick(1); chk("t1 closing", 32'(door), 3);
    tick(1); chk("t1 closing 2nd", 32'(door), 3);
    tick(1); chk("t1 closed", 32'(door), 0);

    // go down to 2, then up-call at 2 with nothing below: opens in place
    car_req = 6'b000100; tick(1); car_req = '0;
    wait_idle("t2 reach2", 200);
    chk("t2 floor2", 32'(floor), 2);
    chk("t2 dir down", 32'(dir_up), 0);
    hall_up_req = 6'b000100; tick(1); hall_up_req = '0;
    chk("t2 up lamp", 32'(hall_up_lit), 4);
    chk("t2 idle door", 32'(door), 0);
    tick(1);
    chk("t2 opening", 32'(door), 1);
    chk("t2 no move", 32'(moving), 0);
    chk("t2 up lamp cleared", 32'(hall_up_lit), 0);
    chk("t2 dir flipped up", 32'(dir_up), 1);
    wait_idle("t2 settle", 200);

    // from 0: car call 5 and down-call 3 -> passes 3, serves 5, returns to 3
    car_req = 6'b000001; tick(1); car_req = '0;
    wait_idle("t3 reach0", 200);
    chk("t3 floor0", 32'(floor), 0);
    chk("t3 dir up at 0", 32'(dir_up), 1);
    car_req = 6'b100000; hall_dn_req = 6'b001000; tick(1);
    car_req = '0; hall_dn_req = '0;
    wait_idle("t3 serve", 400);
    chk("t3 stop count", 32'(n_opens), 2);
    chk("t3 first stop", 32'(opens[0]), 5);
    chk("t3 second stop", 32'(opens[1]), 3);
    chk("t3 final floor", 32'(floor), 3);
    chk("t3 dn lamp cleared", 32'(hall_dn_lit), 0);
    chk("t3 dir down", 32'(dir_up), 0);

    // floor 4: obstruction during closing, then a hold restart while open
    car_req = 6'b010000; tick(1); car_req = '0;
    n = 0;
    while (m_ph != PH_CLOSING && n < 200) begin tick(1); n++; end
    chk("t4 closing reached", 32'(door), 3);
    chk("t4 floor4", 32'(floor), 4);
    door_obstruct = 1'b1; tick(1); door_obstruct = 1'b0;
    chk("t4 reopen", 32'(door), 1);
    tick(1); chk("t4 reopening 2nd", 32'(door), 1);
    tick(1); chk("t4 open again", 32'(door), 2);
    car_req = 6'b010000; tick(1); car_req = '0;
    chk("t4 hold press", 32'(door), 2);
    chk("t4 press not latched", 32'(car_lit), 0);
    tick(2); chk("t4 hold extended", 32'(door), 2);
    tick(1); chk("t4 closing", 32'(door), 3);
    tick(1); chk("t4 closing 2nd", 32'(door), 3);
    tick(1); chk("t4 closed", 32'(door), 0);

    // illegal end-floor hall bits
    hall_up_req = 6'b100000; hall_dn_req = 6'b000001; tick(1);
    hall_up_req = '0; hall_dn_req = '0;
    chk("t5 up lamp 0", 32'(hall_up_lit), 0);
    chk("t5 dn lamp 0", 32'(hall_dn_lit), 0);
    tick(3);
    chk("t5 idle", 32'(moving), 0);
    chk("t5 door", 32'(door), 0);
    chk("t5 floor", 32'(floor), 4);

    // async reset between floors 3 and 2
    car_req = 6'b000001; tick(1); car_req = '0;
    n = 0;
    while (!(m_floor == 3 && m_arr) && n < 200) begin tick(1); n++; end
    chk("t6 at 3", 32'(floor), 3);
    tick(2);
    chk("t6 mid travel", 32'(moving), 1);
    #1 reset = 1'b1;
    #1;
    chk("t6 rst floor", 32'(floor), 0);
    chk("t6 rst door", 32'(door), 0);
    chk("t6 rst moving", 32'(moving), 0);
    chk("t6 rst lamps", 32'({car_lit, hall_up_lit, hall_dn_lit}), 0);
    chk("t6 rst dir", 32'(dir_up), 1);
    tick(2);
    reset = 1'b0;
    tick(4);
    chk("t6 stays idle", 32'(moving), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
